csc3x3_pipe: RTL and testbench

- Parametrised 3x3 colour-space converter, successor to the fixed RGB->YCbCr stage.
- Coefficient and pixel widths are generic. Matrix and offsets are run-time programmable through a double-buffered register bank.
- Valid/ready streaming with backpressure, round-to-nearest, optional saturation.
- Sits between the pixel source and the JPEG/video encoder front end.

---
 rtl/csc_pkg.sv | 26 ++
 rtl/csc_dot3.sv | 98 +++++++++
 rtl/csc3x3_pipe.sv | 116 +++++++++++
 tb/tb_csc3x3_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csc_pkg.sv
// Shared definitions for the 3x3 colour-space converter: configuration
// address map, BT.601 full-range defaults and accumulator sizing.
package csc_pkg;

  // Configuration register map, row-major matrix then offsets.
  typedef enum logic [3:0] {
    ADDR_M11, ADDR_M12, ADDR_M13,
    ADDR_M21, ADDR_M22, ADDR_M23,
    ADDR_M31, ADDR_M32, ADDR_M33,
    ADDR_O1,  ADDR_O2,  ADDR_O3
  } cfg_addr_e;

  // BT.601 full-range RGB->YCbCr, Q1.10 (0x132,0x259,0x075,0x753,0x6AD,0x200,0x200,0x653,0x7AD).
  localparam int BT601_M [9] = '{306, 601, 117, -173, -339, 512, 512, -429, -83};
  localparam int BT601_OFF [3] = '{0, 128, 128};

  // Width that holds three products plus the scaled offset and rounding term.
  function automatic int acc_width(input int dw, input int cw, input int frac);
    int w_sum;
    int w_off;
    w_sum = dw + cw + 3;
    w_off = dw + frac + 3;
    return (w_sum > w_off) ? w_sum : w_off;
  endfunction

endpackage

// File: rtl/csc_dot3.sv
// One output row of the converter: three products (S1), adder tree with
// offset and rounding constant (S2), shift and clip register (S3).
// CSC_SAT_EN selects saturating clip; otherwise the low DW bits wrap.
module csc_dot3
  import csc_pkg::*;
#(
  parameter int DW   = 8,
  parameter int CW   = 11,
  parameter int FRAC = 10,
  parameter int OW   = DW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DW-1:0]        c0,
  input  logic [DW-1:0]        c1,
  input  logic [DW-1:0]        c2,
  input  logic signed [CW-1:0] m1,
  input  logic signed [CW-1:0] m2,
  input  logic signed [CW-1:0] m3,
  input  logic signed [OW-1:0] off,
  output logic [DW-1:0]        y
);

  localparam int PW = DW + CW + 1;
  localparam int AW = acc_width(DW, CW, FRAC);
  localparam logic signed [AW-1:0] RND = AW'(1) <<< (FRAC - 1);
`ifdef CSC_SAT_EN
  localparam logic signed [AW-1:0] Y_MAX = AW'((1 << DW) - 1);
`endif

  logic signed [PW-1:0] prod_d [3];
  logic signed [PW-1:0] prod_q [3];
  logic signed [OW-1:0] off_d, off_q;
  logic signed [AW-1:0] acc_d, acc_q;
  logic [DW-1:0]        y_d, y_q;
  logic signed [AW-1:0] res;

  // Pixel component is unsigned: zero-extend before the signed multiply.
  function automatic logic signed [PW-1:0] mul(input logic signed [CW-1:0] m,
                                               input logic [DW-1:0] c);
    logic signed [PW-1:0] me;
    logic signed [PW-1:0] ce;
    me = PW'(m);
    ce = PW'({1'b0, c});
    return me * ce;
  endfunction

  // Next state of all three stages; everything holds while en is low.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    prod_d = prod_q;
    off_d  = off_q;
    acc_d  = acc_q;
    y_d    = y_q;
    res    = acc_q >>> FRAC;
    if (en) begin
      prod_d[0] = mul(m1, c0);
      prod_d[1] = mul(m2, c1);
      prod_d[2] = mul(m3, c2);
      off_d     = off;
      acc_d     = AW'(prod_q[0]) + AW'(prod_q[1]) + AW'(prod_q[2])
                + (AW'(off_q) <<< FRAC) + RND;
`ifdef CSC_SAT_EN
      if (res < 0)          y_d = '0;
      else if (res > Y_MAX) y_d = '1;
      else                  y_d = res[DW-1:0];
`else
      y_d = res[DW-1:0];
`endif
    end
  end

`ifndef CSC_SAT_EN
  // Upper result bits are deliberately dropped by the wrap-around clip.
  logic unused_res_hi;
  assign unused_res_hi = ^res[AW-1:DW];
`endif

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
    if (!rst_n) begin
      prod_q <= '{default: '0};
      off_q  <= '0;
      acc_q  <= '0;
      y_q    <= '0;
    end else begin
      prod_q <= prod_d;
      off_q  <= off_d;
      acc_q  <= acc_d;
      y_q    <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/csc3x3_pipe.sv
// Programmable 3x3 colour-space converter, 3-stage valid/ready pipeline.
// Double-buffered coefficient bank; the active bank is captured into S1
// together with each pixel. Define CSC_SAT_EN for saturating output clip.
module csc3x3_pipe
  import csc_pkg::*;
#(
  parameter int DW   = 8,
  parameter int CW   = 11,
  parameter int FRAC = 10,
  parameter int OW   = DW + 1,
  parameter int RST_M [9]   = BT601_M,
  parameter int RST_OFF [3] = BT601_OFF
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iValid,
  output logic          oReady,
  input  logic [DW-1:0] iC0,
  input  logic [DW-1:0] iC1,
  input  logic [DW-1:0] iC2,
  output logic          oValid,
  input  logic          iReady,
  output logic [DW-1:0] oC0,
  output logic [DW-1:0] oC1,
  output logic [DW-1:0] oC2,
  input  logic          iCfgWe,
  input  logic [3:0]    iCfgAddr,
  input  logic [CW-1:0] iCfgData,
  input  logic          iCfgCommit
);

  logic signed [CW-1:0] sh_m_q [9], sh_m_d [9], act_m_q [9], act_m_d [9];
  logic signed [OW-1:0] sh_o_q [3], sh_o_d [3], act_o_q [3], act_o_d [3];
  logic [1:0]           o_idx;
  logic [2:0]           vld_d, vld_q;
  logic                 adv, in_fire;
  logic [DW-1:0]        row_y [3];

  // Shadow writes and commit; commit copies the pre-write shadow contents.
  always_comb begin
    sh_m_d  = sh_m_q;
    sh_o_d  = sh_o_q;
    act_m_d = act_m_q;
    act_o_d = act_o_q;
    o_idx   = 2'(iCfgAddr - 4'(ADDR_O1));
    if (iCfgWe) begin
      if (iCfgAddr <= ADDR_M33)     sh_m_d[iCfgAddr] = iCfgData;
      else if (iCfgAddr <= ADDR_O3) sh_o_d[o_idx]    = iCfgData[OW-1:0];
    end
    if (iCfgCommit) begin
      act_m_d = sh_m_q;
      act_o_d = sh_o_q;
    end
  end

  // Coefficient and offset banks.
  always_ff @(posedge iClk) begin
    // NOTE: the banks are reset on purpose: the converter must run BT.601 straight out of reset.
    if (!iRst) begin
      for (int i = 0; i < 9; i++) begin
        sh_m_q[i]  <= CW'(RST_M[i]);
        act_m_q[i] <= CW'(RST_M[i]);
      end
      for (int i = 0; i < 3; i++) begin
        sh_o_q[i]  <= OW'(RST_OFF[i]);
        act_o_q[i] <= OW'(RST_OFF[i]);
      end
    end else begin
      sh_m_q  <= sh_m_d;
      sh_o_q  <= sh_o_d;
      act_m_q <= act_m_d;
      act_o_q <= act_o_d;
    end
  end

  // Shared handshake: the whole pipeline advances only when the output slot frees up.
  always_comb begin
    adv     = !vld_q[2] || iReady;
    in_fire = iValid && adv;
    vld_d   = adv ? {vld_q[1:0], in_fire} : vld_q;
  end

  // Per-stage valid bits.
  always_ff @(posedge iClk) begin
    if (!iRst) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    csc_dot3 #(
      .DW  (DW),
      .CW  (CW),
      .FRAC(FRAC),
      .OW  (OW)
    ) u_row (
      .clk  (iClk),
      .rst_n(iRst),
      .en   (adv),
      .c0   (iC0),
      .c1   (iC1),
      .c2   (iC2),
      .m1   (act_m_q[3*r]),
      .m2   (act_m_q[3*r+1]),
      .m3   (act_m_q[3*r+2]),
      .off  (act_o_q[r]),
      .y    (row_y[r])
    );
  end

  assign oReady = adv;
  assign oValid = vld_q[2];
  assign oC0    = row_y[0];
  assign oC1    = row_y[1];
  assign oC2    = row_y[2];

endmodule

// File: tb/tb_csc3x3_pipe.sv
// Scoreboard bench for csc3x3_pipe: the driver pushes hand-computed
// expected pixels on accept, an independent monitor pops on each output
// transfer. Expectations for the clip cases follow CSC_SAT_EN.
module tb_csc3x3_pipe;

  typedef struct packed {
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
  } pix_t;

`ifdef CSC_SAT_EN
  localparam logic [7:0] RED_CR = 8'd255;
  localparam logic [7:0] NEG_Y  = 8'd0;
`else
  localparam logic [7:0] RED_CR = 8'd0;
  localparam logic [7:0] NEG_Y  = 8'd255;
`endif

  logic        iClk, iRst, iValid, oReady, iReady, oValid;
  logic [7:0]  iC0, iC1, iC2, oC0, oC1, oC2;
  logic        iCfgWe, iCfgCommit;
  logic [3:0]  iCfgAddr;
  logic [10:0] iCfgData;

  pix_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rdy_default = 1'b1;
  bit   bp_en = 1'b0;

  csc3x3_pipe #(.DW(8), .CW(11), .FRAC(10)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iValid    (iValid),
    .oReady    (oReady),
    .iC0       (iC0),
    .iC1       (iC1),
    .iC2       (iC2),
    .oValid    (oValid),
    .iReady    (iReady),
    .oC0       (oC0),
    .oC1       (oC1),
    .oC2       (oC2),
    .iCfgWe    (iCfgWe),
    .iCfgAddr  (iCfgAddr),
    .iCfgData  (iCfgData),
    .iCfgCommit(iCfgCommit)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: either a fixed level or the 1,0,0,1 stall pattern.
  initial begin
    int cyc;
    logic [3:0] pat;
    cyc = 0;
    pat = 4'b1001;
    iReady = 1'b1;
    forever begin
      @(negedge iClk);
      if (bp_en) begin
        iReady = pat[3 - (cyc % 4)];
        cyc++;
      end else begin
        iReady = rdy_default;
        cyc = 0;
      end
    end
  end

  // Monitor: checks every output transfer, stall stability and stall ready.
  initial begin
    pix_t got, exp_pix, held_pix;
    bit held;
    held = 1'b0;
    held_pix = '0;
    forever begin
      @(negedge iClk);
      #2;
      got = {oC0, oC1, oC2};
      if (!iRst) begin
        held = 1'b0;
      end else begin
        if (held && oValid) check("hold_while_stalled", got, held_pix);
        if (oValid && !iReady) check("oready_low_on_stall", oReady, 1'b0);
        if (oValid && iReady) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got 0x%0h with empty scoreboard at %0t", got, $time);
          end else begin
            exp_pix = sb.pop_front();
            check("pixel", got, exp_pix);
          end
        end
        held = oValid && !iReady;
        held_pix = got;
      end
    end
  end

  task automatic send(input logic [7:0] r, g, b, input logic [7:0] e0, e1, e2,
                      input bit commit);
    int guard;
    bit done;
    guard = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge iClk);
      iValid = 1'b1;
      iC0 = r;
      iC1 = g;
      iC2 = b;
      iCfgCommit = commit;
      #1;
      if (oReady) begin
        sb.push_back({e0, e1, e2});
        done = 1'b1;
      end else if (++guard > 100) begin
        check("accept_timeout", {31'd0, oReady}, 32'd1);
        done = 1'b1;
      end
    end
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    iCfgCommit = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [10:0] d, input bit commit);
    @(negedge iClk);
    iCfgWe = 1'b1;
    iCfgAddr = a;
    iCfgData = d;
    iCfgCommit = commit;
    @(posedge iClk);
    #1;
    iCfgWe = 1'b0;
    iCfgCommit = 1'b0;
  endtask

  task automatic cfg_commit();
    @(negedge iClk);
    iCfgCommit = 1'b1;
    @(posedge iClk);
    #1;
    iCfgCommit = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(posedge iClk);
      g++;
    end
    check("drain_scoreboard", sb.size(), 0);
    repeat (3) @(posedge iClk);
  endtask

  initial begin
    iRst = 1'b0;
    iValid = 1'b0;
    iC0 = '0;
    iC1 = '0;
    iC2 = '0;
    iCfgWe = 1'b0;
    iCfgAddr = '0;
    iCfgData = '0;
    iCfgCommit = 1'b0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b1;
    #1;
    check("reset_ovalid", oValid, 1'b0);
    check("reset_oc0", oC0, 8'd0);
    check("reset_oc1", oC1, 8'd0);
    check("reset_oc2", oC2, 8'd0);
    check("reset_oready", oReady, 1'b1);

    // Default BT.601 matrix, plus a 3-cycle latency check on the first pixel.
    send(8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128, 1'b0);
    @(posedge iClk);
    #1;
    check("latency_not_yet", oValid, 1'b0);
    @(posedge iClk);
    #1;
    check("latency_three", oValid, 1'b1);
    send(8'd0, 8'd0, 8'd0, 8'd0, 8'd128, 8'd128, 1'b0);
    send(8'd255, 8'd0, 8'd0, 8'd76, 8'd85, RED_CR, 1'b0);
    wait_drain();

    // Backpressure: 8 grey pixels, (v,v,v) -> (v,128,128), ready toggling 1,0,0,1.
    bp_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(8'(10 * i), 8'(10 * i), 8'(10 * i), 8'(10 * i), 8'd128, 8'd128, 1'b0);
    end
    wait_drain();
    bp_en = 1'b0;

    // Program half-scale diagonal, zero offsets; addresses 12 and 15 are no-ops.
    for (int i = 0; i < 9; i++) begin
      cfg_write(4'(i), (i == 0 || i == 4 || i == 8) ? 11'h200 : 11'h000, 1'b0);
    end
    for (int i = 9; i < 12; i++) cfg_write(4'(i), 11'h000, 1'b0);
    cfg_write(4'd12, 11'h7FF, 1'b0);
    cfg_write(4'd15, 11'h123, 1'b0);
    // Accepted in the commit cycle: still the BT.601 matrix.
    send(8'd200, 8'd100, 8'd50, 8'd124, 8'd86, 8'd182, 1'b1);
    send(8'd200, 8'd100, 8'd50, 8'd100, 8'd50, 8'd25, 1'b0);
    wait_drain();

    // Write M11=0 together with commit: old M11 (0x200) stays active.
    cfg_write(4'd0, 11'h000, 1'b1);
    send(8'd255, 8'd0, 8'd0, 8'd128, 8'd0, 8'd0, 1'b0);
    cfg_commit();
    send(8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    wait_drain();

    // Negative offset (sign-extended 0x1FF = -1) and positive offset 5.
    cfg_write(4'd9, 11'h7FF, 1'b0);
    cfg_write(4'd10, 11'd5, 1'b0);
    cfg_commit();
    send(8'd200, 8'd100, 8'd50, NEG_Y, 8'd55, 8'd25, 1'b0);
    wait_drain();

    // Mid-stream reset with three pixels held in the stalled pipeline.
    rdy_default = 1'b0;
    send(8'd1, 8'd1, 8'd1, 8'd1, 8'd128, 8'd128, 1'b0);
    send(8'd2, 8'd2, 8'd2, 8'd2, 8'd128, 8'd128, 1'b0);
    send(8'd3, 8'd3, 8'd3, 8'd3, 8'd128, 8'd128, 1'b0);
    @(negedge iClk);
    check("full_before_reset", oValid, 1'b1);
    iRst = 1'b0;
    sb.delete();
    @(posedge iClk);
    #1;
    check("midreset_ovalid", oValid, 1'b0);
    @(negedge iClk);
    iRst = 1'b1;
    rdy_default = 1'b1;
    repeat (6) @(posedge iClk);
    #1;
    check("no_stale_after_reset", oValid, 1'b0);
    send(8'd255, 8'd0, 8'd0, 8'd76, 8'd85, RED_CR, 1'b0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
